// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM.
// Sequences the shared ALU/RF/DM/NPC datapath through FETCH, DECODE, EXE, MEM and WB
// for add, sub, ori, lui, lw, sw, beq, jal and jr. Any other encoding retires as a NOP
// from DECODE with the illegal pulse raised.
// Optional build macro MC_PERF_CNT_EN adds retired-instruction and cycle counters;
// without it instr_cnt/cycle_cnt are constant zero and no counter flops exist.
module mc_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_rdy,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic [2:0]       npc_op,
    output logic             ext_op,
    output logic             alub_sel,
    output logic [2:0]       alu_op,
    output logic             dm_wr,
    output logic [1:0]       rf_wd_sel,
    output logic [1:0]       rf_a3_sel,
    output logic             rf_wr,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXE    = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    logic [2:0] cur_state;
    logic [2:0] nxt_state;

    logic is_add, is_sub, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_jal, is_known;

    assign is_add   = (op == OP_RTYPE) && (func == FN_ADD);
    assign is_sub   = (op == OP_RTYPE) && (func == FN_SUB);
    assign is_jr    = (op == OP_RTYPE) && (func == FN_JR);
    assign is_ori   = (op == OP_ORI);
    assign is_lui   = (op == OP_LUI);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_jal   = (op == OP_JAL);
    assign is_known = is_add | is_sub | is_jr | is_ori | is_lui | is_lw | is_sw | is_beq | is_jal;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state sequencing; mem_rdy only matters in FETCH and MEM.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            FETCH:  if (mem_rdy) nxt_state = DECODE;
            DECODE: begin
                if (is_jal)         nxt_state = WB;
                else if (!is_known) nxt_state = FETCH;
                else                nxt_state = EXE;
            end
            EXE: begin
                if (is_beq || is_jr)     nxt_state = FETCH;
                else if (is_lw || is_sw) nxt_state = MEM;
                else                     nxt_state = WB;
            end
            MEM: begin
                if (mem_rdy) nxt_state = is_sw ? FETCH : WB;
            end
            WB:      nxt_state = FETCH;
            default: nxt_state = FETCH;
        endcase
    end

    // Control outputs decoded from state and the latched opcode; all forced low in reset.
    always_comb begin
        ir_wr     = 1'b0;
        pc_wr     = 1'b0;
        npc_op    = 3'd0;
        ext_op    = 1'b0;
        alub_sel  = 1'b0;
        alu_op    = 3'd0;
        dm_wr     = 1'b0;
        rf_wd_sel = 2'd0;
        rf_a3_sel = 2'd0;
        rf_wr     = 1'b0;
        illegal   = 1'b0;
        if (!reset) begin
            case (cur_state)
                FETCH: ir_wr = mem_rdy;
                DECODE: begin
                    // Unknown encodings retire here as a NOP: step PC and flag it.
                    if (!is_known) begin
                        pc_wr   = 1'b1;
                        illegal = 1'b1;
                    end
                end
                EXE, MEM: begin
                    // ALU controls stay stable through MEM so the address does not move.
                    if (is_sub || is_beq) alu_op = 3'd1;
                    else if (is_ori)      alu_op = 3'd2;
                    else if (is_lui)      alu_op = 3'd3;
                    else if (is_jr)       alu_op = 3'd4;
                    ext_op   = is_lw | is_sw | is_beq;
                    alub_sel = is_ori | is_lui | is_lw | is_sw;
                    if (cur_state == EXE) begin
                        if (is_beq) begin
                            pc_wr  = 1'b1;
                            npc_op = zero ? 3'd1 : 3'd0;
                        end else if (is_jr) begin
                            pc_wr  = 1'b1;
                            npc_op = 3'd3;
                        end
                    end else if (is_sw) begin
                        dm_wr = mem_rdy;
                        pc_wr = mem_rdy;
                    end
                end
                WB: begin
                    rf_wr = 1'b1;
                    pc_wr = 1'b1;
                    if (is_add || is_sub) begin
                        rf_a3_sel = 2'd1;
                    end else if (is_lw) begin
                        rf_wd_sel = 2'd1;
                    end else if (is_jal) begin
                        rf_a3_sel = 2'd2;
                        rf_wd_sel = 2'd2;
                        npc_op    = 3'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state = reset ? FETCH : cur_state;

`ifdef MC_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] icnt;
    logic [CNT_W-1:0] ccnt;

    // Free-running counters; pc_wr marks exactly one retire per instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            icnt <= '0;
            ccnt <= '0;
        end else begin
            ccnt <= ccnt + CNT_ONE;
            if (pc_wr) icnt <= icnt + CNT_ONE;
        end
    end

    assign instr_cnt = reset ? '0 : icnt;
    assign cycle_cnt = reset ? '0 : ccnt;
`else
    assign instr_cnt = '0;
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: table of single instructions plus hand-built
// sequences for stalls, reset mid-instruction and the optional counters.
module tb_mc_controller;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [5:0]       op = 6'h00;
    logic [5:0]       func = 6'h20;
    logic             zero = 1'b0;
    logic             mem_rdy = 1'b1;
    logic             ir_wr, pc_wr, ext_op, alub_sel, dm_wr, rf_wr, illegal;
    logic [2:0]       npc_op, alu_op, state;
    logic [1:0]       rf_wd_sel, rf_a3_sel;
    logic [CNT_W-1:0] instr_cnt, cycle_cnt;

    always #5 clk = ~clk;

    mc_controller #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .func      (func),
        .zero      (zero),
        .mem_rdy   (mem_rdy),
        .ir_wr     (ir_wr),
        .pc_wr     (pc_wr),
        .npc_op    (npc_op),
        .ext_op    (ext_op),
        .alub_sel  (alub_sel),
        .alu_op    (alu_op),
        .dm_wr     (dm_wr),
        .rf_wd_sel (rf_wd_sel),
        .rf_a3_sel (rf_a3_sel),
        .rf_wr     (rf_wr),
        .illegal   (illegal),
        .state     (state),
        .instr_cnt (instr_cnt),
        .cycle_cnt (cycle_cnt)
    );

    // One expected observation per clock cycle.
    typedef struct {
        string      name;
        logic [2:0] st;
        logic       ir, pc, dm, rf, ill;
        logic [2:0] npc;
        logic [1:0] a3, wd;
        logic [2:0] alu;
        logic       ext, alub;
        bit         chk_npc, chk_rf, chk_alu;
    } obs_t;

    // One single-instruction vector with mem_rdy held high.
    typedef struct {
        string      name;
        logic [5:0] op, func;
        logic       z;
        int         n;
        int         st[5];
        logic [2:0] npc;
        logic [1:0] a3, wd;
        logic       rfw, dmw, ill;
        logic [2:0] alu;
        logic       ext, alub;
        bit         has_alu;
    } vec_t;

    obs_t sbq[$];
    vec_t vecs[12];
    int   n_tests = 0;
    int   n_fail = 0;

    function automatic obs_t mk(string name, logic [2:0] st, logic ir, logic pc, logic dm,
                                logic rf, logic ill);
        obs_t e;
        e.name = name; e.st = st; e.ir = ir; e.pc = pc; e.dm = dm; e.rf = rf; e.ill = ill;
        e.npc = 3'd0; e.a3 = 2'd0; e.wd = 2'd0; e.alu = 3'd0; e.ext = 1'b0; e.alub = 1'b0;
        e.chk_npc = 1'b0; e.chk_rf = 1'b0; e.chk_alu = 1'b0;
        return e;
    endfunction

    function automatic obs_t with_alu(obs_t e, logic [2:0] alu, logic ext, logic alub);
        e.alu = alu; e.ext = ext; e.alub = alub; e.chk_alu = 1'b1;
        return e;
    endfunction

    function automatic obs_t with_ret(obs_t e, logic [2:0] npc, logic [1:0] a3, logic [1:0] wd,
                                      bit chk_rf);
        e.npc = npc; e.chk_npc = 1'b1; e.a3 = a3; e.wd = wd; e.chk_rf = chk_rf;
        return e;
    endfunction

    function automatic vec_t mkv(string name, logic [5:0] vop, logic [5:0] vfn, logic z,
                                 int n, int s0, int s1, int s2, int s3, int s4,
                                 logic [2:0] npc, logic [1:0] a3, logic [1:0] wd, logic rfw,
                                 logic dmw, logic ill, logic [2:0] alu, logic ext, logic alub,
                                 bit has_alu);
        vec_t v;
        v.name = name; v.op = vop; v.func = vfn; v.z = z; v.n = n;
        v.st[0] = s0; v.st[1] = s1; v.st[2] = s2; v.st[3] = s3; v.st[4] = s4;
        v.npc = npc; v.a3 = a3; v.wd = wd; v.rfw = rfw; v.dmw = dmw; v.ill = ill;
        v.alu = alu; v.ext = ext; v.alub = alub; v.has_alu = has_alu;
        return v;
    endfunction

    task automatic check_one(obs_t e);
        bit ok;
        ok = (state === e.st) && (ir_wr === e.ir) && (pc_wr === e.pc) && (dm_wr === e.dm) &&
             (rf_wr === e.rf) && (illegal === e.ill);
        if (e.chk_npc && npc_op !== e.npc) ok = 1'b0;
        if (e.chk_rf && (rf_a3_sel !== e.a3 || rf_wd_sel !== e.wd)) ok = 1'b0;
        if (e.chk_alu && (alu_op !== e.alu || ext_op !== e.ext || alub_sel !== e.alub)) ok = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got st=%0d ir=%b pc=%b dm=%b rf=%b ill=%b npc=%0d a3=%0d wd=%0d alu=%0d ext=%b alub=%b; want st=%0d ir=%b pc=%b dm=%b rf=%b ill=%b npc=%0d a3=%0d wd=%0d alu=%0d ext=%b alub=%b",
                     e.name, state, ir_wr, pc_wr, dm_wr, rf_wr, illegal, npc_op, rf_a3_sel,
                     rf_wd_sel, alu_op, ext_op, alub_sel, e.st, e.ir, e.pc, e.dm, e.rf, e.ill,
                     e.npc, e.a3, e.wd, e.alu, e.ext, e.alub);
        end
    endtask

    task automatic check_val(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    // Each cycle starts at a falling edge: drive, settle, compare against the scoreboard.
    task automatic run_cycles(int n, logic [15:0] rdy, logic [15:0] rst, logic z);
        for (int k = 0; k < n; k++) begin
            reset = rst[k];
            mem_rdy = rdy[k];
            zero = z;
            #1;
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_underrun: got empty queue, want an entry");
            end else begin
                check_one(sbq.pop_front());
            end
            @(negedge clk);
        end
    endtask

    task automatic push_vec(vec_t v);
        obs_t e;
        for (int k = 0; k < v.n; k++) begin
            e = mk(v.name, v.st[k][2:0], (v.st[k] == 0), 1'b0, 1'b0, 1'b0, 1'b0);
            if (v.st[k] == 2 && v.has_alu) e = with_alu(e, v.alu, v.ext, v.alub);
            if (k == v.n - 1) begin
                e.pc = 1'b1; e.dm = v.dmw; e.rf = v.rfw; e.ill = v.ill;
                e = with_ret(e, v.npc, v.a3, v.wd, v.rfw);
            end
            sbq.push_back(e);
        end
    endtask

    task automatic run_vec(vec_t v);
        op = v.op;
        func = v.func;
        push_vec(v);
        run_cycles(v.n, 16'hffff, 16'h0000, v.z);
    endtask

    task automatic do_reset();
        obs_t e;
        e = mk("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e = with_ret(e, 3'd0, 2'd0, 2'd0, 1'b1);
        e = with_alu(e, 3'd0, 1'b0, 1'b0);
        sbq.push_back(e);
        run_cycles(1, 16'hffff, 16'hffff, 1'b0);
    endtask

    initial begin
        obs_t e;
        //               name       op     func   z  n  states         npc a3 wd rf dm il alu ext alub has
        vecs[0]  = mkv("add",     6'h00, 6'h20, 0, 4, 0, 1, 2, 4, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1);
        vecs[1]  = mkv("sub",     6'h00, 6'h22, 0, 4, 0, 1, 2, 4, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 1);
        vecs[2]  = mkv("ori",     6'h0d, 6'h15, 0, 4, 0, 1, 2, 4, 0, 0, 0, 0, 1, 0, 0, 2, 0, 1, 1);
        vecs[3]  = mkv("lui",     6'h0f, 6'h00, 0, 4, 0, 1, 2, 4, 0, 0, 0, 0, 1, 0, 0, 3, 0, 1, 1);
        vecs[4]  = mkv("lw",      6'h23, 6'h04, 0, 5, 0, 1, 2, 3, 4, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1);
        vecs[5]  = mkv("sw",      6'h2b, 6'h08, 0, 4, 0, 1, 2, 3, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1);
        vecs[6]  = mkv("beq_tkn", 6'h04, 6'h00, 1, 3, 0, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        vecs[7]  = mkv("beq_nt",  6'h04, 6'h00, 0, 3, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        vecs[8]  = mkv("jal",     6'h03, 6'h00, 0, 3, 0, 1, 4, 0, 0, 2, 2, 2, 1, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mkv("jr",      6'h00, 6'h08, 0, 3, 0, 1, 2, 0, 0, 3, 0, 0, 0, 0, 0, 4, 0, 0, 1);
        vecs[10] = mkv("ill_op",  6'h3f, 6'h20, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[11] = mkv("ill_fn",  6'h00, 6'h21, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        @(negedge clk);
        do_reset();

        foreach (vecs[i]) run_vec(vecs[i]);

        // FETCH stall: IR not loaded until memory is ready.
        op = 6'h00; func = 6'h20;
        sbq.push_back(mk("fstall0", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        sbq.push_back(mk("fstall1", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        sbq.push_back(mk("fstall_go", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        sbq.push_back(mk("fstall_dec", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        sbq.push_back(with_alu(mk("fstall_exe", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 3'd0, 1'b0, 1'b0));
        sbq.push_back(with_ret(mk("fstall_wb", 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 3'd0, 2'd1, 2'd0, 1'b1));
        run_cycles(6, 16'h003c, 16'h0000, 1'b0);

        // lw with two not-ready MEM cycles: 7 cycles total, ALU controls held.
        op = 6'h23; func = 6'h00;
        sbq.push_back(mk("lws_f", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        sbq.push_back(mk("lws_d", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        sbq.push_back(with_alu(mk("lws_e", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 3'd0, 1'b1, 1'b1));
        sbq.push_back(with_alu(mk("lws_m0", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 3'd0, 1'b1, 1'b1));
        sbq.push_back(with_alu(mk("lws_m1", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 3'd0, 1'b1, 1'b1));
        sbq.push_back(with_alu(mk("lws_m2", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 3'd0, 1'b1, 1'b1));
        sbq.push_back(with_ret(mk("lws_wb", 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), 3'd0, 2'd0, 2'd1, 1'b1));
        run_cycles(7, 16'h0067, 16'h0000, 1'b0);

        // sw with one not-ready MEM cycle: write only when memory is ready.
        op = 6'h2b;
        sbq.push_back(mk("sws_f", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        sbq.push_back(mk("sws_d", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        sbq.push_back(with_alu(mk("sws_e", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 3'd0, 1'b1, 1'b1));
        sbq.push_back(mk("sws_m0", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        e = mk("sws_m1", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        sbq.push_back(with_ret(e, 3'd0, 2'd0, 2'd0, 1'b0));
        run_cycles(5, 16'h0017, 16'h0000, 1'b0);

        // Reset in MEM of sw: no store, back to FETCH, then a clean sw.
        sbq.push_back(mk("swr_f", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        sbq.push_back(mk("swr_d", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        sbq.push_back(mk("swr_e", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        sbq.push_back(mk("swr_mem_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        sbq.push_back(mk("swr_refetch", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        sbq.push_back(mk("swr_d2", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        sbq.push_back(mk("swr_e2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        sbq.push_back(mk("swr_m2", 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        run_cycles(8, 16'hffff, 16'h0008, 1'b0);

`ifdef MC_PERF_CNT_EN
        // 20 adds = 80 cycles: instr_cnt 20 mod 16, cycle_cnt 80 mod 16.
        do_reset();
        for (int i = 0; i < 20; i++) run_vec(vecs[0]);
        #1;
        check_val("instr_cnt_wrap", 32'(instr_cnt), 32'd4);
        check_val("cycle_cnt_wrap", 32'(cycle_cnt), 32'd0);
`else
        #1;
        check_val("instr_cnt_off", 32'(instr_cnt), 32'd0);
        check_val("cycle_cnt_off", 32'(cycle_cnt), 32'd0);
`endif

        check_val("scoreboard_drained", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
